vga_rect_filler: RTL and testbench
==================================

# vga_rect_filler

Framebuffer drawing engine that sits directly upstream of the VGA scan-out stage. It accepts rectangle-fill commands over a valid/ready handshake and emits one framebuffer write per cycle on the `wr_en`/`wr_addr`/`wr_data` port that the VGA block's pixel memory consumes. It clips each rectangle to the visible area and computes addresses incrementally, with no multiplier in the pixel loop. It raises a one-cycle `done` pulse when each command finishes.

## Interface
- `H_RES`, 640: visible pixels per line.
- `V_RES`, 480: visible lines.
- `COLOR_BITS`, 12: width of `cmd_color` and `wr_data` (4 bits each of R, G, B).
- `ADDR_WIDTH`, 19: framebuffer address width. Must satisfy H_RES*V_RES ≤ 2^ADDR_WIDTH.
- `clk`, input, 1: sole clock. Same clock as the VGA pixel logic.
- `rst`, input, 1: reset. Asynchronous and active-high.
- `cmd_valid`, input, 1: a command is presented.
- `cmd_ready`, output, 1: the engine can accept a command.
- `cmd_x0`, `cmd_x1`, input, 10: inclusive column bounds.
- `cmd_y0`, `cmd_y1`, input, 9: inclusive row bounds.
- `cmd_color`, input, COLOR_BITS: fill value.
- `wr_en`, output, 1: a write request is valid.
- `wr_ready`, input, 1: the memory accepts the write this cycle.
- `wr_addr`, output, ADDR_WIDTH: linear address, y*H_RES + x.
- `wr_data`, output, COLOR_BITS: pixel value.
- `busy`, output, 1: a command is in progress.
- `done`, output, 1: one-cycle completion pulse.

## Operation
- **States:** IDLE, SETUP, FILL, DONE.
- **Reset values:** state = IDLE, `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `busy` = 0, `done` = 0. `cmd_ready` = 1, since it is decoded as state==IDLE.
- **IDLE:**
  - Command accepted when `cmd_valid && cmd_ready`.
  - On acceptance, all cmd_* fields are latched and the state moves to SETUP. Later changes on cmd_* are ignored.
- **SETUP (one cycle), clipping:**
  - `x1c` = min(x1, H_RES-1).
  - `y1c` = min(y1, V_RES-1).
  - The command is empty if x0 ≥ H_RES, y0 ≥ V_RES, x0 > x1c, or y0 > y1c.
  - Empty command: go to DONE with zero writes.
  - Otherwise: `row_base` = y0*H_RES, computed by shift-add since H_RES is constant. `wr_addr` = row_base + x0, cursor = (x0, y0), `wr_en` = 1, `wr_data` = color. Go to FILL.
- **FILL:**
  - A write completes in any cycle with `wr_en && wr_ready`.
  - While `wr_ready` = 0, `wr_addr` and `wr_data` hold and `wr_en` stays 1.
  - On a completed write, the cursor advances in raster order:
    - If x < x1c: x++ and `wr_addr`++.
    - Else if y < y1c: x = x0, y++, `row_base` += H_RES, and `wr_addr` = new `row_base` + x0.
    - Else this was the last pixel: `wr_en` drops to 0 next cycle and the state moves to DONE.
- **DONE (one cycle):** `done` = 1, `busy` = 1, then return to IDLE.
- **busy:** 1 in SETUP, FILL and DONE.
- **Address arithmetic:**
  - Unsigned, ADDR_WIDTH bits.
  - The maximum address is H_RES*V_RES-1 = 307199, so no wrap occurs.
  - Addresses are never emitted outside the clipped rectangle.
- **Reset during a command:** the command aborts immediately. `wr_en` drops asynchronously, no `done` is issued, and the remaining pixels are never written.

## Timing
- Command accepted in cycle T. SETUP occupies T+1. The first write request is visible in T+2.
- With `wr_ready` held at 1, an N-pixel rectangle writes in cycles T+2 … T+N+1.
- `done` is high in cycle T+N+2. `cmd_ready` is 1 again in T+N+3.
- Each cycle with `wr_ready` = 0 during FILL adds exactly one cycle to this schedule.
- Empty command: SETUP in T+1, `done` in T+2, `cmd_ready` in T+3, and `wr_en` never asserted.
- `cmd_ready` is 0 from T+1 until IDLE is re-entered, so there is no command overlap.
- All outputs except `cmd_ready` are registered.

## Test plan
- **Reset state:** assert `rst` mid-cycle with no clock → `wr_en` = 0, `done` = 0, `busy` = 0, `cmd_ready` = 1. Release and idle for 10 cycles → no writes.
- **2×2 fill:** x 10..11, y 5..6, color 0xF00, `wr_ready` = 1. Required: addresses 3210, 3211, 3850, 3851, each with data 0xF00, in cycles T+2..T+5. `done` in T+6.
- **Clipping:** x 638..700, y 479..500, color 0x0A0 → exactly two writes, at 307198 and 307199. Then x0 = 640 → zero writes, `done` at T+2.
- **Backpressure:** 1×3 rectangle at (0,0) with `wr_ready` low for 2 cycles on the second pixel → address 1 held for 3 cycles, total writes = 3, `done` delayed by 2 cycles.
- **Full screen:** 0..639 × 0..479 → 307200 writes, monotonic addresses 0..307199, `done` at T+307202.
- **Reset mid-fill:** assert `rst` after 5 writes of a 4×4 fill → `wr_en` falls immediately, no `done`. After release, a new command is accepted normally.

Source files
------------

// File: rtl/vga_rect_filler.sv
// Rectangle-fill engine feeding the VGA pixel memory: clips each command to the
// visible area and walks it in raster order, one write per accepted cycle.
module vga_rect_filler #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int COLOR_BITS = 12,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [9:0]            cmd_x0,
  input  logic [9:0]            cmd_x1,
  input  logic [8:0]            cmd_y0,
  input  logic [8:0]            cmd_y1,
  input  logic [COLOR_BITS-1:0] cmd_color,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [COLOR_BITS-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;

  localparam logic [9:0]            X_MAX  = 10'(H_RES - 1);
  localparam logic [8:0]            Y_MAX  = 9'(V_RES - 1);
  localparam logic [ADDR_WIDTH-1:0] H_STEP = ADDR_WIDTH'(H_RES);

  // y*H_RES as a sum of shifted copies of y, one per set bit of the constant.
  function automatic logic [ADDR_WIDTH-1:0] row_of(input logic [8:0] y);
    logic [ADDR_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_WIDTH; i++)
      if (((H_RES >> i) & 1) != 0) acc = acc + (ADDR_WIDTH'(y) << i);
    return acc;
  endfunction

  state_t                state_q, state_d;
  logic [9:0]            x0_q, x0_d, x1_q, x1_d, x_q, x_d;
  logic [8:0]            y0_q, y0_d, y1_q, y1_d, y_q, y_d;
  logic [COLOR_BITS-1:0] color_q, color_d, wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d, wr_addr_q, wr_addr_d;
  logic                  wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
  logic [9:0]            x1c;
  logic [8:0]            y1c;
  logic                  empty;

  assign cmd_ready = (state_q == S_IDLE);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    x1c   = (x1_q > X_MAX) ? X_MAX : x1_q;
    y1c   = (y1_q > Y_MAX) ? Y_MAX : y1_q;
    empty = (int'(x0_q) >= H_RES) || (int'(y0_q) >= V_RES) || (x0_q > x1c) || (y0_q > y1c);
  end

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    color_d    = color_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = wr_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          x0_d    = cmd_x0;
          x1_d    = cmd_x1;
          y0_d    = cmd_y0;
          y1_d    = cmd_y1;
          color_d = cmd_color;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (empty) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          // Bounds are replaced by their clipped values for the fill walk.
          x1_d       = x1c;
          y1_d       = y1c;
          x_d        = x0_q;
          y_d        = y0_q;
          row_base_d = row_of(y0_q);
          wr_addr_d  = row_of(y0_q) + ADDR_WIDTH'(x0_q);
          wr_data_d  = color_q;
          wr_en_d    = 1'b1;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (wr_ready) begin
          if (x_q < x1_q) begin
            x_d       = x_q + 10'd1;
            wr_addr_d = wr_addr_q + 1'b1;
          end else if (y_q < y1_q) begin
            x_d        = x0_q;
            y_d        = y_q + 9'd1;
            row_base_d = row_base_q + H_STEP;
            wr_addr_d  = row_base_q + H_STEP + ADDR_WIDTH'(x0_q);
          end else begin
            wr_en_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      color_q    <= color_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_vga_rect_filler.sv
// Bench for vga_rect_filler: a raster-order pixel list model predicts every write
// and the done/busy/ready timing; directed cases pin known addresses and latencies.
module tb_vga_rect_filler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x0 = '0, cmd_x1 = '0;
  logic [8:0]  cmd_y0 = '0, cmd_y1 = '0;
  logic [11:0] cmd_color = '0;
  logic        wr_en;
  logic        wr_ready = 1'b1;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        busy, done;

  vga_rect_filler dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the command becomes the list of clipped pixels in raster order.
  int  exp_q[$];
  int  obs_q[$];
  int  m_color, m_t, m_n, m_stalls;
  bit  m_active = 0;
  bit  in_fill, done_exp;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wr_en", wr_en, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      exp_q.delete();
      m_active = 0;
    end else begin
      in_fill  = m_active && (cyc >= m_t + 2) && (cyc < m_t + m_n + 2 + m_stalls);
      done_exp = m_active && (cyc == m_t + m_n + 2 + m_stalls);
      chk("cmd_ready", cmd_ready, !m_active);
      chk("busy", busy, m_active);
      chk("wr_en", wr_en, in_fill);
      chk("done", done, done_exp);
      if (wr_en && in_fill) begin
        chk("pending_pixels", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("wr_addr", wr_addr, exp_q[0]);
          chk("wr_data", wr_data, m_color);
          if (wr_ready) begin
            obs_q.push_back(int'(wr_addr));
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_fill && !wr_ready) m_stalls++;
      if (done_exp) begin
        chk("all_pixels_written", exp_q.size(), 0);
        m_active = 0;
      end else if (!m_active && cmd_valid && cmd_ready) begin
        int x1c, y1c;
        x1c = (int'(cmd_x1) > 639) ? 639 : int'(cmd_x1);
        y1c = (int'(cmd_y1) > 479) ? 479 : int'(cmd_y1);
        exp_q.delete();
        for (int y = int'(cmd_y0); y <= y1c; y++)
          for (int x = int'(cmd_x0); x <= x1c; x++)
            exp_q.push_back(y * 640 + x);
        m_n      = exp_q.size();
        m_color  = int'(cmd_color);
        m_t      = cyc;
        m_stalls = 0;
        m_active = 1;
      end
    end
  end

  // wr_ready modes: 0 always ready, 1 random, 2 low in cycles T+3 and T+4.
  int rdy_mode = 0;
  int bp_t = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       wr_ready = ($urandom_range(0, 3) != 0);
      2:       wr_ready = !((cyc == bp_t + 3) || (cyc == bp_t + 4));
      default: wr_ready = 1'b1;
    endcase
  end

  task automatic present(input int x0, x1, y0, y1, input int col, output int t);
    bit acc;
    acc = 0;
    t = -1;
    cmd_x0 = 10'(x0); cmd_x1 = 10'(x1); cmd_y0 = 9'(y0); cmd_y1 = 9'(y1);
    cmd_color = 12'(col);
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = 1;
        t = cyc;
        bp_t = cyc;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    // Scramble the fields to show the engine works from its latched copy.
    cmd_x0 = 10'($urandom); cmd_x1 = 10'($urandom);
    cmd_y0 = 9'($urandom);  cmd_y1 = 9'($urandom);
    cmd_color = 12'($urandom);
    if (!acc) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic run_cmd(input int x0, x1, y0, y1, input int col, output int lat);
    int t;
    lat = -1;
    obs_q.delete();
    present(x0, x1, y0, y1, col, t);
    if (t < 0) return;
    for (int i = 0; i < 20000 && lat < 0; i++) begin
      @(negedge clk);
      if (done) lat = cyc - t;
    end
    if (lat < 0) chk("done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #40_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t, nw, x0, y0;
    #2;
    chk("init_wr_en", wr_en, 0);
    chk("init_done", done, 0);
    chk("init_busy", busy, 0);
    chk("init_cmd_ready", cmd_ready, 1);
    chk("init_wr_addr", wr_addr, 0);
    chk("init_wr_data", wr_data, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    obs_q.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("idle_no_writes", obs_q.size(), 0);

    // 2x2 fill
    run_cmd(10, 11, 5, 6, 12'hF00, lat);
    chk("fill2x2_latency", lat, 6);
    chk("fill2x2_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk("fill2x2_a0", obs_q[0], 3210);
      chk("fill2x2_a1", obs_q[1], 3211);
      chk("fill2x2_a2", obs_q[2], 3850);
      chk("fill2x2_a3", obs_q[3], 3851);
    end

    // Clipping at bottom-right corner, then a fully off-screen command
    run_cmd(638, 700, 479, 500, 12'h0A0, lat);
    chk("clip_count", obs_q.size(), 2);
    chk("clip_latency", lat, 4);
    if (obs_q.size() == 2) begin
      chk("clip_a0", obs_q[0], 307198);
      chk("clip_a1", obs_q[1], 307199);
    end
    run_cmd(640, 700, 0, 10, 12'h123, lat);
    chk("empty_count", obs_q.size(), 0);
    chk("empty_latency", lat, 2);
    run_cmd(20, 10, 0, 0, 12'h321, lat);
    chk("inverted_count", obs_q.size(), 0);
    chk("inverted_latency", lat, 2);

    // Backpressure on the second pixel of a 1x3
    rdy_mode = 2;
    run_cmd(0, 2, 0, 0, 12'h00F, lat);
    rdy_mode = 0;
    chk("bp_latency", lat, 7);
    chk("bp_count", obs_q.size(), 3);

    // Ten full-width rows at the bottom of the screen
    run_cmd(0, 639, 470, 479, 12'hABC, lat);
    chk("wide_latency", lat, 6402);
    chk("wide_count", obs_q.size(), 6400);
    if (obs_q.size() == 6400) chk("wide_last", obs_q[6399], 307199);

    // Reset after five writes of a 4x4
    present(100, 103, 20, 23, 12'h555, t);
    nw = 0;
    for (int i = 0; i < 40 && nw < 5; i++) begin
      @(negedge clk);
      if (wr_en && wr_ready) nw++;
    end
    chk("midfill_writes_seen", nw, 5);
    #2 rst = 1'b1;
    #1;
    chk("midfill_wr_en_async", wr_en, 0);
    chk("midfill_done", done, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    obs_q.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_no_writes", obs_q.size(), 0);
    run_cmd(1, 2, 1, 1, 12'h777, lat);
    chk("post_reset_latency", lat, 4);
    chk("post_reset_count", obs_q.size(), 2);

    // Random commands with random backpressure
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      x0 = $urandom_range(0, 700);
      y0 = $urandom_range(0, 500);
      if ($urandom_range(0, 7) == 0)
        run_cmd(x0, x0 - $urandom_range(1, 5), y0, y0 + $urandom_range(0, 4), $urandom, lat);
      else
        run_cmd(x0, (x0 + $urandom_range(0, 12)) & 1023, y0,
                (y0 + $urandom_range(0, 6)) & 511, $urandom, lat);
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
